// File: rtl/bloom_pkg.sv
// Shared types and constants for the Bloom-filter rule writer and its hash mix.
// Optional BLOOM_WR_STATS_EN build adds insert/bit-write counters in the writer.
package bloom_pkg;

  localparam int unsigned IP_W    = 72;
  localparam int unsigned PORT_W  = 16;
  localparam logic [31:0] SEED_STEP = 32'h9E3779B9;
  localparam int unsigned HASH_LAT  = 4;

  localparam int unsigned ROT_1 = 14;
  localparam int unsigned ROT_2 = 11;
  localparam int unsigned ROT_3 = 25;
  localparam int unsigned ROT_4 = 16;

  // Writer FSM encoding
  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_HASH  = 3'd1;
  localparam logic [ST_W-1:0] ST_WRITE = 3'd2;
  localparam logic [ST_W-1:0] ST_CLEAR = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE  = 3'd4;

  typedef struct packed {
    logic [IP_W-1:0]   ip;
    logic [PORT_W-1:0] src;
    logic [PORT_W-1:0] dst;
  } rule_t;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] seed_of(input logic [31:0] base, input logic [31:0] i);
    return base + i * SEED_STEP;
  endfunction

endpackage

// File: rtl/bloom_rule_writer_if.sv
// Rule-load handshake plus arbitrated BRAM write port of the Bloom rule writer.
interface bloom_rule_writer_if
  import bloom_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) ();

  logic              in_valid;
  logic              in_ready;
  logic [IP_W-1:0]   in_ip_protocol;
  logic [PORT_W-1:0] in_src_port;
  logic [PORT_W-1:0] in_dst_port;
  logic              clear_req;
  logic              busy;
  logic              done;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_wdata;
  logic              bram_gnt;

  modport master (
    input  in_valid, in_ip_protocol, in_src_port, in_dst_port, clear_req, bram_gnt,
    output in_ready, busy, done, bram_we, bram_addr, bram_wdata
  );

  modport slave (
    output in_valid, in_ip_protocol, in_src_port, in_dst_port, clear_req, bram_gnt,
    input  in_ready, busy, done, bram_we, bram_addr, bram_wdata
  );

endinterface

// File: rtl/bloom_hash_mix.sv
// Four-cycle seeded 32-bit key mix; shared with the lookup side so addresses match.
module bloom_hash_mix
  import bloom_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] seed,
  input  logic [31:0] k0,
  input  logic [31:0] k1,
  input  logic [31:0] k2,
  output logic [31:0] hash,
  output logic        valid
);

  logic [31:0]         a_q, b_q, c_q;
  logic [HASH_LAT-1:0] stg_q;
  logic [31:0]         a_ld, b_ld, c_ld;

  always_comb begin
    a_ld = k0 + seed;
    b_ld = k1 + seed;
    c_ld = k2 ^ seed;
  end

  // Load and first round share the start edge; one round per following stage
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      stg_q <= '0;
    end else begin
      stg_q <= {stg_q[HASH_LAT-2:0], start};
      if (start) begin
        a_q <= a_ld;
        b_q <= b_ld;
        c_q <= (c_ld ^ b_ld) - rotl32(b_ld, ROT_1);
      end else begin
        if (stg_q[0]) a_q <= (a_q ^ c_q) - rotl32(c_q, ROT_2);
        if (stg_q[1]) b_q <= (b_q ^ a_q) - rotl32(a_q, ROT_3);
        if (stg_q[2]) c_q <= (c_q ^ b_q) - rotl32(b_q, ROT_4);
      end
    end
  end

  assign hash  = c_q;
  assign valid = stg_q[HASH_LAT-1];

endmodule

// File: rtl/bloom_rule_writer.sv
// Sets NUM_HASH hashed bits per rule tuple in the filter BRAM, or sweeps it to 0.
// Define BLOOM_WR_STATS_EN to build the stat_keys/stat_bits counters.
module bloom_rule_writer
  import bloom_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned NUM_HASH  = 3,
  parameter logic [31:0] SEED_BASE = 32'hDEADBEEF
) (
  input  logic                clk,
  input  logic                rst,
  bloom_rule_writer_if.master bus,
  output logic [31:0]         stat_keys,
  output logic [31:0]         stat_bits
);

  localparam int unsigned IDX_W = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_HASH - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  logic [ST_W-1:0]   state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wdata_q, wdata_d;
  logic              busy_q, done_q;
  rule_t             rule_q, in_rule_c, key_c;
  logic              start_c, cap_c;
  logic [31:0]       seed_c, k2_c, hash_c;
  logic              hash_vld_c;

  assign in_rule_c = '{ip: bus.in_ip_protocol, src: bus.in_src_port, dst: bus.in_dst_port};
  // First hash starts in the handshake cycle, straight from the input bus
  assign key_c  = (state_q == ST_IDLE) ? in_rule_c : rule_q;
  assign k2_c   = {key_c.ip[7:0], 24'h0} ^ {key_c.src, key_c.dst};
  assign seed_c = seed_of(SEED_BASE, 32'(idx_d));

  bloom_hash_mix u_mix (
    .clk   (clk),
    .rst   (rst),
    .start (start_c),
    .seed  (seed_c),
    .k0    (key_c.ip[71:40]),
    .k1    (key_c.ip[39:8]),
    .k2    (k2_c),
    .hash  (hash_c),
    .valid (hash_vld_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    start_c = 1'b0;
    cap_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        we_d = 1'b0;
        if (bus.clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          we_d    = 1'b1;
          addr_d  = '0;
          wdata_d = 1'b0;
        end else if (bus.in_valid) begin
          state_d = ST_HASH;
          idx_d   = '0;
          start_c = 1'b1;
          cap_c   = 1'b1;
        end
      end
      ST_HASH: begin
        if (hash_vld_c) begin
          state_d = ST_WRITE;
          we_d    = 1'b1;
          addr_d  = hash_c[ADDR_W-1:0];
          wdata_d = 1'b1;
        end
      end
      ST_WRITE: begin
        if (bus.bram_gnt) begin
          we_d = 1'b0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_HASH;
            start_c = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        if (bus.bram_gnt) begin
          if (cnt_q == ADDR_LAST) begin
            state_d = ST_DONE;
            cnt_d   = '0;
            we_d    = 1'b0;
          end else begin
            cnt_d  = cnt_q + ADDR_W'(1);
            addr_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs and datapath, all following the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rule_q  <= '0;
    end else begin
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      if (cap_c) rule_q <= in_rule_c;
    end
  end

  assign bus.in_ready   = (state_q == ST_IDLE) && !bus.clear_req && !rst;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.bram_we    = we_q;
  assign bus.bram_addr  = addr_q;
  assign bus.bram_wdata = wdata_q;

`ifdef BLOOM_WR_STATS_EN
  logic [31:0] keys_q, bits_q;
  logic        bit_wr_c, key_done_c, clr_done_c;

  assign bit_wr_c   = (state_q == ST_WRITE) && bus.bram_gnt;
  assign key_done_c = bit_wr_c && (idx_q == IDX_LAST);
  assign clr_done_c = (state_q == ST_CLEAR) && bus.bram_gnt && (cnt_q == ADDR_LAST);

  // Saturating counters, zeroed when a clear completes
  always_ff @(posedge clk) begin
    if (rst || clr_done_c) begin
      keys_q <= '0;
      bits_q <= '0;
    end else begin
      if (bit_wr_c && (bits_q != 32'hFFFF_FFFF))   bits_q <= bits_q + 32'd1;
      if (key_done_c && (keys_q != 32'hFFFF_FFFF)) keys_q <= keys_q + 32'd1;
    end
  end

  assign stat_keys = keys_q;
  assign stat_bits = bits_q;
`else
  assign stat_keys = '0;
  assign stat_bits = '0;
`endif

endmodule

// File: tb/tb_bloom_rule_writer.sv
// Directed self-checking bench for bloom_rule_writer (ADDR_W=4, NUM_HASH=3).
module tb_bloom_rule_writer;

  localparam int unsigned AW = 4;
  localparam int unsigned NH = 3;
  localparam logic [31:0] SB = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] stat_keys, stat_bits;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  bloom_rule_writer_if #(.ADDR_W(AW)) bus ();

  bloom_rule_writer #(.ADDR_W(AW), .NUM_HASH(NH), .SEED_BASE(SB)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .stat_keys (stat_keys),
    .stat_bits (stat_bits)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] ref_hash(input logic [71:0] ip, input logic [15:0] s,
                                           input logic [15:0] d, input int i);
    logic [31:0] seed, a, b, c;
    seed = SB + 32'(i) * 32'h9E3779B9;
    a = ip[71:40] + seed;
    b = ip[39:8] + seed;
    c = ({ip[7:0], 24'h0} ^ {s, d}) ^ seed;
    c = (c ^ b) - rl(b, 14);
    a = (a ^ c) - rl(c, 11);
    b = (b ^ a) - rl(a, 25);
    c = (c ^ b) - rl(b, 16);
    return c;
  endfunction

  task automatic check_stats(input string tag, input int k, input int b);
`ifdef BLOOM_WR_STATS_EN
    check({tag, " keys"}, stat_keys, 32'(k));
    check({tag, " bits"}, stat_bits, 32'(b));
`else
    check({tag, " keys"}, stat_keys, 32'(k - k));
    check({tag, " bits"}, stat_bits, 32'(b - b));
`endif
  endtask

  task automatic drive_rule(input logic v, input logic [71:0] ip, input logic [15:0] s,
                            input logic [15:0] d);
    bus.in_valid       = v;
    bus.in_ip_protocol = ip;
    bus.in_src_port    = s;
    bus.in_dst_port    = d;
  endtask

  // Handshake in cycle 0, returns at the negedge of cycle 1 with inputs dropped
  task automatic send(input string tag, input logic [71:0] ip, input logic [15:0] s,
                      input logic [15:0] d);
    @(negedge clk);
    check({tag, " hs ready"}, 32'(bus.in_ready), 32'd1);
    drive_rule(1'b1, ip, s, d);
    @(negedge clk);
    drive_rule(1'b0, '0, '0, '0);
  endtask

  // Called at the negedge of cycle 1 after the handshake; returns in the done cycle
  task automatic observe_insert(input string tag, input logic [71:0] ip, input logic [15:0] s,
                                input logic [15:0] d, input int stall);
    int          wi;
    int          held;
    bit          fin;
    logic [31:0] h;
    wi = 0; held = 0; fin = 1'b0;
    for (int cyc = 1; cyc <= 80 && !fin; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (bus.done) begin
        check({tag, " done cycle"}, 32'(cyc), 32'(5 * NH + 1 + stall));
        check({tag, " writes"}, 32'(wi), 32'(NH));
        fin = 1'b1;
      end else begin
        check({tag, " ready low"}, 32'(bus.in_ready), 32'd0);
        check({tag, " busy"}, 32'(bus.busy), 32'd1);
        if (bus.bram_we) begin
          h = ref_hash(ip, s, d, wi);
          check({tag, " addr"}, 32'(bus.bram_addr), 32'(h[AW-1:0]));
          check({tag, " wdata"}, 32'(bus.bram_wdata), 32'd1);
          if (wi == 0 && held < stall) begin
            bus.bram_gnt = 1'b0;
            held++;
          end else begin
            bus.bram_gnt = 1'b1;
            wi++;
          end
        end else begin
          bus.bram_gnt = 1'b1;
        end
      end
    end
    if (!fin) check({tag, " timeout"}, 32'd0, 32'd1);
    bus.bram_gnt = 1'b1;
  endtask

  logic [71:0] ip_a, ip_b, ip_c;
  int          ci;
  bit          fin, hit, seen_done;

  initial begin
    ip_a = 72'h00c0a80130c0a80130;
    ip_b = 72'h1122334455667788a5;
    ip_c = 72'hfedcba9876543210_3c;
    rst = 1'b1;
    bus.clear_req = 1'b0;
    bus.bram_gnt  = 1'b1;
    drive_rule(1'b0, '0, '0, '0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst in_ready", 32'(bus.in_ready), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst we", 32'(bus.bram_we), 32'd0);
    check("rst addr", 32'(bus.bram_addr), 32'd0);
    check("rst wdata", 32'(bus.bram_wdata), 32'd0);
    check_stats("rst", 0, 0);
    rst = 1'b0;
    #1 check("post-rst ready", 32'(bus.in_ready), 32'd1);

    // Golden tuple, grant tied high
    send("insA", ip_a, 16'd16538, 16'd37281);
    observe_insert("insA", ip_a, 16'd16538, 16'd37281, 0);
    check_stats("insA", 1, 3);
    @(negedge clk);
    check("insA idle busy", 32'(bus.busy), 32'd0);

    // Seven-cycle grant stall on the first write
    send("insB", ip_b, 16'h0050, 16'hbeef);
    observe_insert("insB", ip_b, 16'h0050, 16'hbeef, 7);
    check_stats("insB", 2, 6);

    // Clear wins over a simultaneous tuple, which is then taken right after done
    @(negedge clk);
    bus.clear_req = 1'b1;
    drive_rule(1'b1, ip_c, 16'h1234, 16'h0001);
    #1 check("clr ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.clear_req = 1'b0;
    ci = 0; fin = 1'b0;
    for (int cyc = 1; cyc <= 60 && !fin; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (bus.done) begin
        check("clr done cycle", 32'(cyc), 32'd17);
        check("clr writes", 32'(ci), 32'd16);
        fin = 1'b1;
      end else begin
        check("clr ready low", 32'(bus.in_ready), 32'd0);
        if (bus.bram_we) begin
          check("clr addr", 32'(bus.bram_addr), 32'(ci));
          check("clr wdata", 32'(bus.bram_wdata), 32'd0);
          ci++;
        end
      end
    end
    if (!fin) check("clr timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("post-clr ready", 32'(bus.in_ready), 32'd1);
    check_stats("clr", 0, 0);
    @(negedge clk);
    drive_rule(1'b0, '0, '0, '0);
    observe_insert("insC", ip_c, 16'h1234, 16'h0001, 0);
    check_stats("insC", 1, 3);

    // Reset during the second write
    send("abort", ip_a, 16'h0101, 16'h0202);
    hit = 1'b0;
    ci = 0;
    for (int cyc = 1; cyc <= 40 && !hit; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (bus.bram_we) begin
        if (ci == 1) begin
          rst = 1'b1;
          hit = 1'b1;
        end else begin
          ci++;
        end
      end
    end
    if (!hit) check("abort timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("abort we", 32'(bus.bram_we), 32'd0);
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    check("abort no done", 32'(seen_done), 32'd0);
    check_stats("abort", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
